// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//
// EX-stage branch resolution unit. It works alongside the fetch-side branch
// predictor. Each fetched instruction's prediction (taken flag and predicted
// target) travels with it through two pipe stages (D, E). When a conditional
// branch reaches EX, this unit:
//   - evaluates the branch,
//   - computes its target,
//   - compares the result against the prediction.
// The outcome is registered and sent two ways:
//   - as a redirect/flush request to the front end, and
//   - as an update strobe to the predictor tables.
// Two performance counters track resolved branches and mispredictions.
//
// Ports
//   cpu_clk, cpu_rstn      clock, asynchronous active-low reset
//   stall                  global hold: pipe, FSM and counters freeze
//   if_valid, pc_if        IF-stage instruction and its PC
//   predict_taken_if       predictor direction for pc_if
//   predict_target_pc_if   predictor target for pc_if
//   is_branch_ex           EX instruction is a conditional branch
//   funct3_ex              branch type (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   src_data1_ex/2_ex      forwarded rs1/rs2 operands
//   imm_ex                 sign-extended B-immediate
//   mispredict             one-cycle redirect pulse
//   redirect_pc            fetch restart PC (valid with mispredict)
//   flush_active           kill the IF/DEC instructions
//   branch_ex              predictor update strobe
//   branch_taken_ex        resolved direction
//   branch_pc_ex           PC of the resolved branch
//   branch_target_pc       computed target (pc + imm)
//   branch_cnt             resolved branch count
//   mispredict_cnt         misprediction count
// -----------------------------------------------------------------------------
module branch_resolve #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2,   // legal range 1..7
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  stall,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] pc_if,
  input  logic                  predict_taken_if,
  input  logic [ADDR_WIDTH-1:0] predict_target_pc_if,
  input  logic                  is_branch_ex,
  input  logic [2:0]            funct3_ex,
  input  logic [DATA_WIDTH-1:0] src_data1_ex,
  input  logic [DATA_WIDTH-1:0] src_data2_ex,
  input  logic [ADDR_WIDTH-1:0] imm_ex,
  output logic                  mispredict,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  flush_active,
  output logic                  branch_ex,
  output logic                  branch_taken_ex,
  output logic [ADDR_WIDTH-1:0] branch_pc_ex,
  output logic [ADDR_WIDTH-1:0] branch_target_pc,
  output logic [CNT_WIDTH-1:0]  branch_cnt,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Prediction record that accompanies an instruction down the pipe.
  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  ptaken;
    logic [ADDR_WIDTH-1:0] ptarget;
  } pred_t;

  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  pred_t                 d_q, d_d;
  pred_t                 e_q, e_d;
  state_t                state_q, state_d;
  logic [2:0]            fcnt_q, fcnt_d;
  logic                  flush_q, flush_d;

  logic                  branch_ex_q, branch_ex_d;
  logic                  taken_q, taken_d;
  logic [ADDR_WIDTH-1:0] bpc_q, bpc_d;
  logic [ADDR_WIDTH-1:0] btarget_q, btarget_d;
  logic                  mispredict_q, mispredict_d;
  logic [ADDR_WIDTH-1:0] redirect_q, redirect_d;
  logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]  mispredict_cnt_q, mispredict_cnt_d;

  // ---------------------------------------------------------------------------
  // Resolution (combinational, EX cycle)
  // ---------------------------------------------------------------------------
  logic                  cond_taken;
  logic                  resolve;
  logic                  miss;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] fallthrough;

  // NOTE: every always_comb output gets a default before any branch so that
  // no path leaves it unassigned; otherwise a latch would be inferred.
  always_comb begin
    cond_taken = 1'b0;
    case (funct3_ex)
      F3_BEQ:  cond_taken = (src_data1_ex == src_data2_ex);
      F3_BNE:  cond_taken = (src_data1_ex != src_data2_ex);
      F3_BLT:  cond_taken = ($signed(src_data1_ex) <  $signed(src_data2_ex));
      F3_BGE:  cond_taken = ($signed(src_data1_ex) >= $signed(src_data2_ex));
      F3_BLTU: cond_taken = (src_data1_ex <  src_data2_ex);
      F3_BGEU: cond_taken = (src_data1_ex >= src_data2_ex);
      default: cond_taken = 1'b0;   // 010/011 are not branch encodings
    endcase
  end

  // Both sums wrap modulo 2^ADDR_WIDTH. Truncation is intentional.
  assign target      = e_q.pc + imm_ex;
  assign fallthrough = e_q.pc + ADDR_WIDTH'(4);

  // Branches that reach EX during a flush are wrong-path work, so they are
  // ignored.
  assign resolve = e_q.valid & is_branch_ex & ~stall & (state_q == IDLE);

  // A correct direction still counts as a miss when the predicted target of a
  // taken branch is stale.
  assign miss = (cond_taken & ~e_q.ptaken)
              | (~cond_taken & e_q.ptaken)
              | (cond_taken & e_q.ptaken & (e_q.ptarget != target));

  // ---------------------------------------------------------------------------
  // Prediction pipe: D <- IF, E <- D. The flush kills both stages.
  // ---------------------------------------------------------------------------
  always_comb begin
    d_d = d_q;
    e_d = e_q;
    if (!stall) begin
      d_d.valid   = if_valid & ~flush_q;
      d_d.pc      = pc_if;
      d_d.ptaken  = predict_taken_if;
      d_d.ptarget = predict_target_pc_if;
      e_d         = d_q;
      e_d.valid   = d_q.valid & ~flush_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Flush FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (!stall) begin
      case (state_q)
        IDLE: begin
          if (resolve && miss) begin
            state_d = FLUSH;
            fcnt_d  = FCNT_INIT;
          end
        end
        FLUSH: begin
          if (fcnt_q == 3'd0) begin
            state_d = IDLE;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
          fcnt_d  = 3'd0;
        end
      endcase
    end
  end

  // flush_active is registered. It goes high in the same cycle as the
  // mispredict pulse, so the front end sees the redirect and the kill
  // together.
  assign flush_d = (state_d == FLUSH);

  // ---------------------------------------------------------------------------
  // Registered resolution outputs and performance counters
  // ---------------------------------------------------------------------------
  always_comb begin
    branch_ex_d      = resolve;
    mispredict_d     = resolve & miss;
    taken_d          = taken_q;
    bpc_d            = bpc_q;
    btarget_d        = btarget_q;
    redirect_d       = redirect_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (resolve) begin
      taken_d      = cond_taken;
      bpc_d        = e_q.pc;
      btarget_d    = target;
      branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
      if (miss) begin
        redirect_d       = cond_taken ? target : fallthrough;
        mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      d_q              <= '0;
      e_q              <= '0;
      state_q          <= IDLE;
      fcnt_q           <= 3'd0;
      flush_q          <= 1'b0;
      branch_ex_q      <= 1'b0;
      taken_q          <= 1'b0;
      bpc_q            <= '0;
      btarget_q        <= '0;
      mispredict_q     <= 1'b0;
      redirect_q       <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      d_q              <= d_d;
      e_q              <= e_d;
      state_q          <= state_d;
      fcnt_q           <= fcnt_d;
      flush_q          <= flush_d;
      branch_ex_q      <= branch_ex_d;
      taken_q          <= taken_d;
      bpc_q            <= bpc_d;
      btarget_q        <= btarget_d;
      mispredict_q     <= mispredict_d;
      redirect_q       <= redirect_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_q;
  assign flush_active     = flush_q;
  assign branch_ex        = branch_ex_q;
  assign branch_taken_ex  = taken_q;
  assign branch_pc_ex     = bpc_q;
  assign branch_target_pc = btarget_q;
  assign branch_cnt       = branch_cnt_q;
  assign mispredict_cnt   = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
//
// Scoreboard bench for branch_resolve.
//
// The driver issues one stimulus cycle at a time. It runs a behavioural
// reference model that treats the pipe as a two-entry in-flight queue plus a
// flush budget, and pushes two kinds of expected results:
//   - a per-cycle record of control outputs, and
//   - a transaction for each resolved branch.
// A separate monitor, on the falling edge, compares the DUT outputs against
// these queues.
// -----------------------------------------------------------------------------
module tb_branch_resolve;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int FC = 2;
  localparam int CW = 32;

  logic          cpu_clk  = 1'b0;
  logic          cpu_rstn = 1'b0;
  logic          stall    = 1'b0;
  logic          if_valid = 1'b0;
  logic [AW-1:0] pc_if    = '0;
  logic          predict_taken_if     = 1'b0;
  logic [AW-1:0] predict_target_pc_if = '0;
  logic          is_branch_ex = 1'b0;
  logic [2:0]    funct3_ex    = '0;
  logic [DW-1:0] src_data1_ex = '0;
  logic [DW-1:0] src_data2_ex = '0;
  logic [AW-1:0] imm_ex       = '0;
  logic          mispredict;
  logic [AW-1:0] redirect_pc;
  logic          flush_active;
  logic          branch_ex;
  logic          branch_taken_ex;
  logic [AW-1:0] branch_pc_ex;
  logic [AW-1:0] branch_target_pc;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] mispredict_cnt;

  branch_resolve #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .stall(stall),
    .if_valid(if_valid), .pc_if(pc_if), .predict_taken_if(predict_taken_if),
    .predict_target_pc_if(predict_target_pc_if), .is_branch_ex(is_branch_ex),
    .funct3_ex(funct3_ex), .src_data1_ex(src_data1_ex),
    .src_data2_ex(src_data2_ex), .imm_ex(imm_ex), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .flush_active(flush_active),
    .branch_ex(branch_ex), .branch_taken_ex(branch_taken_ex),
    .branch_pc_ex(branch_pc_ex), .branch_target_pc(branch_target_pc),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit        v;
    bit [31:0] pc;
    bit        pt;
    bit [31:0] ptg;
  } fetch_t;

  typedef struct {
    bit        st, iv, pt, isb;
    bit [31:0] pc, ptg, s1, s2, imm;
    bit [2:0]  f3;
  } stim_t;

  typedef struct {
    int        cyc;
    bit        flush, bex, mis, tk;
    bit [31:0] bpc, btgt, rpc, bcnt, mcnt;
  } ctl_t;

  typedef struct {
    bit        tk, mis;
    bit [31:0] pc, tgt, rpc;
  } txn_t;

  fetch_t    inflight[$];   // [0] = younger (decode), [1] = instruction in EX
  int        flush_left;    // remaining non-stalled flush cycles
  bit        m_tk;
  bit [31:0] m_bpc, m_btgt, m_rpc, m_bcnt, m_mcnt;
  ctl_t      ctl_q[$];
  txn_t      txn_q[$];

  function automatic bit ref_taken(bit [2:0] f3, bit [31:0] a, bit [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    fetch_t empty;
    empty.v = 1'b0; empty.pc = '0; empty.pt = 1'b0; empty.ptg = '0;
    inflight.delete();
    inflight.push_back(empty);
    inflight.push_back(empty);
    flush_left = 0;
    m_tk = 1'b0; m_bpc = '0; m_btgt = '0; m_rpc = '0; m_bcnt = '0; m_mcnt = '0;
    ctl_q.delete();
    txn_q.delete();
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s.st = 1'b0; s.iv = 1'b0; s.pt = 1'b0; s.isb = 1'b0;
    s.pc = '0; s.ptg = '0; s.s1 = '0; s.s2 = '0; s.imm = '0; s.f3 = '0;
    return s;
  endfunction

  // Drive one cycle of stimulus and predict the outputs for the next cycle.
  task automatic step(input stim_t s);
    fetch_t    ex, nf;
    bit        flushing, res, tk, miss;
    bit [31:0] tgt, fall;
    ctl_t      c;
    txn_t      t;
    @(posedge cpu_clk);
    #1;
    stall = s.st; if_valid = s.iv; pc_if = s.pc; predict_taken_if = s.pt;
    predict_target_pc_if = s.ptg; is_branch_ex = s.isb; funct3_ex = s.f3;
    src_data1_ex = s.s1; src_data2_ex = s.s2; imm_ex = s.imm;

    ex       = inflight[1];
    flushing = (flush_left > 0);
    res      = ex.v && s.isb && !s.st && !flushing;
    tk       = ref_taken(s.f3, s.s1, s.s2);
    tgt      = ex.pc + s.imm;
    fall     = ex.pc + 32'd4;
    miss     = (tk != ex.pt) || (tk && ex.pt && (ex.ptg != tgt));
    if (res) begin
      m_tk = tk; m_bpc = ex.pc; m_btgt = tgt; m_bcnt = m_bcnt + 1;
      if (miss) begin
        m_rpc  = tk ? tgt : fall;
        m_mcnt = m_mcnt + 1;
      end
      t.tk = tk; t.mis = miss; t.pc = ex.pc; t.tgt = tgt; t.rpc = m_rpc;
      txn_q.push_back(t);
    end
    if (!s.st) begin
      if (flushing) flush_left--;
      if (res && miss) flush_left = FC;
      nf.v = s.iv && !flushing; nf.pc = s.pc; nf.pt = s.pt; nf.ptg = s.ptg;
      inflight[0].v = inflight[0].v && !flushing;
      void'(inflight.pop_back());
      inflight.push_front(nf);
    end
    c.cyc = cyc + 1; c.flush = (flush_left > 0); c.bex = res; c.mis = res && miss;
    c.tk = m_tk; c.bpc = m_bpc; c.btgt = m_btgt; c.rpc = m_rpc;
    c.bcnt = m_bcnt; c.mcnt = m_mcnt;
    ctl_q.push_back(c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(nop());
  endtask

  // Fetch one instruction, let it reach EX as a branch, then advance to T+1.
  task automatic branch_case(input bit [31:0] pc, input bit pt, input bit [31:0] ptg,
                             input bit [2:0] f3, input bit [31:0] s1,
                             input bit [31:0] s2, input bit [31:0] imm);
    stim_t s;
    s = nop(); s.iv = 1'b1; s.pc = pc; s.pt = pt; s.ptg = ptg;
    step(s);
    step(nop());
    s = nop(); s.isb = 1'b1; s.f3 = f3; s.s1 = s1; s.s2 = s2; s.imm = imm;
    step(s);
    step(nop());
    @(negedge cpu_clk);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  ctl_t mon_c;
  txn_t mon_t;

  always @(negedge cpu_clk) begin
    if (cpu_rstn) begin
      if (ctl_q.size() > 0 && ctl_q[0].cyc == cyc) begin
        mon_c = ctl_q.pop_front();
        check("flush_active",     64'(flush_active),     64'(mon_c.flush));
        check("branch_ex",        64'(branch_ex),        64'(mon_c.bex));
        check("mispredict",       64'(mispredict),       64'(mon_c.mis));
        check("branch_taken_ex",  64'(branch_taken_ex),  64'(mon_c.tk));
        check("branch_pc_ex",     64'(branch_pc_ex),     64'(mon_c.bpc));
        check("branch_target_pc", 64'(branch_target_pc), 64'(mon_c.btgt));
        check("redirect_pc",      64'(redirect_pc),      64'(mon_c.rpc));
        check("branch_cnt",       64'(branch_cnt),       64'(mon_c.bcnt));
        check("mispredict_cnt",   64'(mispredict_cnt),   64'(mon_c.mcnt));
      end
      if (branch_ex) begin
        if (txn_q.size() == 0) begin
          check("unexpected_branch_ex", 64'(branch_ex), 64'(0));
        end else begin
          mon_t = txn_q.pop_front();
          check("txn_taken",  64'(branch_taken_ex),  64'(mon_t.tk));
          check("txn_pc",     64'(branch_pc_ex),     64'(mon_t.pc));
          check("txn_target", 64'(branch_target_pc), 64'(mon_t.tgt));
          check("txn_miss",   64'(mispredict),       64'(mon_t.mis));
          if (mon_t.mis) check("txn_redirect", 64'(redirect_pc), 64'(mon_t.rpc));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  bit [31:0] edge_vals [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

  initial begin
    stim_t s;
    int    flush_cnt;
    bit [12:0] r;

    model_reset();
    repeat (3) @(posedge cpu_clk);
    #1 cpu_rstn = 1'b1;

    // Idle after reset: everything stays zero.
    idle(10);
    @(negedge cpu_clk);
    check("reset_flush", 64'(flush_active), 64'(0));
    check("reset_bcnt",  64'(branch_cnt),   64'(0));

    // Correctly predicted taken BEQ.
    branch_case(32'h100, 1'b1, 32'h140, 3'b000, 32'd5, 32'd5, 32'h40);
    check("beq_bex",    64'(branch_ex),        64'(1));
    check("beq_taken",  64'(branch_taken_ex),  64'(1));
    check("beq_target", 64'(branch_target_pc), 64'(32'h140));
    check("beq_mis",    64'(mispredict),       64'(0));
    check("beq_bcnt",   64'(branch_cnt),       64'(1));
    idle(4);

    // BLT taken (signed) but predicted not-taken: redirect, 2-cycle flush.
    branch_case(32'h100, 1'b0, 32'h0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h40);
    check("blt_mis",   64'(mispredict),     64'(1));
    check("blt_rpc",   64'(redirect_pc),    64'(32'h140));
    check("blt_mcnt",  64'(mispredict_cnt), 64'(1));
    check("blt_fl0",   64'(flush_active),   64'(1));
    step(nop()); @(negedge cpu_clk);
    check("blt_fl1",   64'(flush_active),   64'(1));
    step(nop()); @(negedge cpu_clk);
    check("blt_fl2",   64'(flush_active),   64'(0));
    idle(4);

    // BLTU not taken but predicted taken: redirect to fallthrough.
    branch_case(32'h100, 1'b1, 32'h140, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h40);
    check("bltu_taken", 64'(branch_taken_ex), 64'(0));
    check("bltu_rpc",   64'(redirect_pc),     64'(32'h104));
    idle(6);

    // Target mismatch, younger branch squashed, stall mid-flush.
    s = nop(); s.iv = 1'b1; s.pc = 32'h100; s.pt = 1'b1; s.ptg = 32'h200; step(s);
    s = nop(); s.iv = 1'b1; s.pc = 32'h104; s.pt = 1'b0; step(s);
    s = nop(); s.isb = 1'b1; s.s1 = 32'd5; s.s2 = 32'd5; s.imm = 32'h40; step(s);
    step(s);
    @(negedge cpu_clk);
    check("tgt_mis", 64'(mispredict),  64'(1));
    check("tgt_rpc", 64'(redirect_pc), 64'(32'h140));
    flush_cnt = flush_active ? 1 : 0;
    s.st = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(s); @(negedge cpu_clk);
      if (flush_active) flush_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      step(nop()); @(negedge cpu_clk);
      if (flush_active) flush_cnt++;
    end
    check("stall_flush_len", 64'(flush_cnt),  64'(5));
    check("squash_bcnt",     64'(branch_cnt), 64'(4));
    idle(3);

    // PC wrap on fallthrough, then reset in the middle of the flush.
    branch_case(32'hFFFF_FFFC, 1'b1, 32'h10, 3'b001, 32'd7, 32'd7, 32'h14);
    check("wrap_rpc",  64'(redirect_pc),  64'(0));
    @(posedge cpu_clk); #1;
    check("prereset_flush", 64'(flush_active), 64'(1));
    cpu_rstn = 1'b0;
    s = nop();
    stall = s.st; if_valid = s.iv; is_branch_ex = s.isb;
    model_reset();
    #1;
    check("rst_flush", 64'(flush_active),   64'(0));
    check("rst_bcnt",  64'(branch_cnt),     64'(0));
    check("rst_mcnt",  64'(mispredict_cnt), 64'(0));
    check("rst_mis",   64'(mispredict),     64'(0));
    check("rst_bex",   64'(branch_ex),      64'(0));
    repeat (2) @(posedge cpu_clk);
    #1 cpu_rstn = 1'b1;

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      s     = nop();
      s.st  = ($urandom_range(0, 9) == 0);
      s.iv  = ($urandom_range(0, 9) < 7);
      s.pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                         : ($urandom & 32'hFFFF_FFFC);
      s.pt  = $urandom_range(0, 1) == 1;
      s.ptg = $urandom & 32'hFFFF_FFFE;
      s.isb = ($urandom_range(0, 9) < 6);
      s.f3  = 3'($urandom_range(0, 7));
      s.s1  = ($urandom_range(0, 1) == 1) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      s.s2  = ($urandom_range(0, 2) == 0) ? s.s1
            : (($urandom_range(0, 1) == 1) ? edge_vals[$urandom_range(0, 4)] : $urandom);
      r     = 13'($urandom);
      s.imm = {{19{r[12]}}, r[12:1], 1'b0};
      if (inflight[1].v && $urandom_range(0, 1) == 1)
        s.imm = inflight[1].ptg - inflight[1].pc;
      step(s);
    end
    idle(5);
    @(negedge cpu_clk);
    check("txn_drained", 64'(txn_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- EX-stage branch resolution unit; counterpart of the fetch-side branch predictor.
- Carries each fetched instruction's prediction (taken flag, target) through IF→DEC→EX, evaluates the conditional branch in EX, and detects mispredictions.
- Drives the redirect/flush to the front end and the registered update (branch_ex, branch_taken_ex, branch_pc_ex, branch_target_pc) back to the predictor tables.
- Keeps branch and mispredict performance counters.

Parameters:
ADDR_WIDTH, 32, PC width
DATA_WIDTH, 32, operand width
FLUSH_CYCLES, 2, cycles flush_active stays high after a mispredict (kills IF and DEC); legal range 1..7
CNT_WIDTH, 32, performance counter width

Ports:
cpu_clk  in  1  clock
cpu_rstn  in  1  reset; asynchronous, active-low
stall  in  1  global pipeline hold; pipe registers and FSM hold; counters do not advance
if_valid  in  1  IF stage holds a valid fetched instruction
pc_if  in  ADDR_WIDTH  PC of IF instruction
predict_taken_if  in  1  predictor taken flag for pc_if
predict_target_pc_if  in  ADDR_WIDTH  predicted target for pc_if
is_branch_ex  in  1  EX instruction is a conditional branch (from decode pipe)
funct3_ex  in  3  branch type
src_data1_ex  in  DATA_WIDTH  rs1 operand (forwarded)
src_data2_ex  in  DATA_WIDTH  rs2 operand (forwarded)
imm_ex  in  ADDR_WIDTH  sign-extended B-immediate
mispredict  out  1  one-cycle redirect pulse
redirect_pc  out  ADDR_WIDTH  fetch restart PC, valid with mispredict
flush_active  out  1  kill IF/DEC instructions
branch_ex  out  1  predictor update strobe
branch_taken_ex  out  1  resolved direction
branch_pc_ex  out  ADDR_WIDTH  PC of resolved branch
branch_target_pc  out  ADDR_WIDTH  computed target pc+imm
branch_cnt  out  CNT_WIDTH  resolved branch count
mispredict_cnt  out  CNT_WIDTH  mispredict count

Behaviour:
- Reset (async, cpu_rstn low): all outputs 0, pipe valid bits 0, FSM IDLE, counters 0. Reset mid-flush: returns to IDLE immediately.
- Prediction pipe:
  - Stage D holds {valid, pc, ptaken, ptarget}; stage E holds the same fields.
  - Each non-stall cycle: D←IF fields with valid=if_valid, and E←D.
  - stall=1: both stages hold.
  - flush_active=1 (and not stalled): D.valid and E.valid load 0.
- Resolution (combinational, cycle T): resolve = E.valid & is_branch_ex & ~stall & (state==IDLE).
- Direction from funct3_ex:
  - 000 BEQ: equal
  - 001 BNE: not equal
  - 100 BLT: signed less-than
  - 101 BGE: signed greater-or-equal
  - 110 BLTU: unsigned less-than
  - 111 BGEU: unsigned greater-or-equal
  - 010/011: not taken.
- Target: target = E.pc + imm_ex, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH). Fallthrough = E.pc + 4, same wrap rule.
- Mispredict condition:
  - (taken & ~E.ptaken), or
  - (~taken & E.ptaken), or
  - (taken & E.ptaken & E.ptarget != target).
- Redirect PC: target if taken, else fallthrough.
- Registered outputs at cycle T+1 (1-cycle latency):
  - branch_ex = resolve, for exactly one cycle.
  - branch_taken_ex, branch_pc_ex, branch_target_pc update only when resolve, otherwise hold.
  - mispredict = resolve & miss, for one cycle; redirect_pc loads only on a mispredict.
- FSM, states IDLE and FLUSH, with a 3-bit counter fcnt:
  - IDLE → FLUSH on resolve & miss; fcnt←FLUSH_CYCLES-1.
  - In FLUSH, flush_active=1. Each non-stall cycle: fcnt decrements; at fcnt==0, go to IDLE.
  - Stall freezes the FSM. flush_active is a registered function of state.
  - Branches reaching EX while in FLUSH are not resolved: no update, no count.
- Counters (wrap at 2^CNT_WIDTH):
  - branch_cnt increments on resolve.
  - mispredict_cnt increments on resolve & miss.
  - Both increment in the same edge as the T+1 outputs become visible.
- Non-branch in EX with E.valid: no action.
- Branch with E.valid=0: no action.

Test Plan:
- Reset release, no traffic → all outputs 0, flush_active 0, counters 0 for 10 cycles.
- pc_if=0x100, predict_taken=1, ptarget=0x140; BEQ, src1=src2=5, imm=0x40 reaching EX → branch_ex=1, branch_taken_ex=1, branch_target_pc=0x140, mispredict=0, branch_cnt=1.
- Same pc predicted not-taken; BLT with src1=0xFFFFFFFF, src2=1 (taken, signed) → mispredict=1 at T+1, redirect_pc=0x140, flush_active high exactly 2 cycles, mispredict_cnt=1.
- BLTU with src1=0xFFFFFFFF, src2=1 predicted taken to 0x140 → not taken, redirect_pc=0x104, branch_taken_ex=0.
- Taken with target mismatch: ptarget=0x200, actual 0x140 → mispredict=1, redirect_pc=0x140. A second branch already in DEC is squashed (no branch_ex for it). stall asserted 3 cycles mid-flush → flush_active stays high 2+3 cycles.
- Wrap and reset: pc=0xFFFFFFFC with a not-taken branch → redirect_pc=0x00000000. cpu_rstn pulsed low during FLUSH → flush_active=0 and counters=0 immediately.
